dm_bridge: RTL and testbench

- Sits directly downstream of the MEM stage, on the far side of its DM port (DM_PC, DM_Addr, DM_WData, DM_WE, DM_RData).
- Contains the word-organised data RAM with byte-lane writes and a memory-mapped countdown timer (TC0) with an interrupt output.
- Address-decodes each access to RAM, timer or unmapped space, and returns read data combinationally within the same cycle. MEM latches memWord at the same edge.

---
 rtl/dm_bridge_pkg.sv | 33 +++
 rtl/dm_bridge_tc_timer.sv | 118 +++++++++++
 rtl/dm_bridge.sv | 95 +++++++++
 tb/tb_dm_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_bridge_pkg.sv
// rtl/dm_bridge_pkg.sv - shared constants and encodings for the DM bridge and its timer
package dm_bridge_pkg;

    localparam logic [31:0] TC_BASE       = 32'h0000_7F00;
    localparam logic [31:0] TC_CTRL_OFF   = 32'd0;
    localparam logic [31:0] TC_PRESET_OFF = 32'd4;
    localparam logic [31:0] TC_COUNT_OFF  = 32'd8;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    // Modes 10 and 11 are not named; they fall back to one-shot behaviour.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Which timer word the current address selects.
    typedef enum logic [1:0] {
        TC_SEL_NONE   = 2'd0,
        TC_SEL_CTRL   = 2'd1,
        TC_SEL_PRESET = 2'd2,
        TC_SEL_COUNT  = 2'd3
    } tc_sel_e;

endpackage

// File: rtl/dm_bridge_tc_timer.sv
// rtl/dm_bridge_tc_timer.sv - TC0 countdown timer: registers, FSM and interrupt
module dm_bridge_tc_timer
    import dm_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sel,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        int_flag;

    tc_state_e   state;
    tc_state_e   state_nxt;

    logic        do_load;
    logic        do_dec;
    logic        do_zero;
    logic        do_set;
    logic        do_disarm;

    logic        wr_ctrl;
    logic        wr_preset;

    assign wr_ctrl   = wr && (sel == TC_SEL_CTRL);
    assign wr_preset = wr && (sel == TC_SEL_PRESET);

    // State register; reset aborts any count in progress immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= TC_IDLE;
        else        state <= state_nxt;
    end

    // Next state from the pre-edge register values.
    always_comb begin
        state_nxt = state;
        case (state)
            TC_IDLE: if (en) state_nxt = TC_LOAD;
            TC_LOAD: state_nxt = TC_CNT;
            TC_CNT: begin
                if (!en)                 state_nxt = TC_IDLE;
                else if (count <= 32'd1) state_nxt = TC_INT;
            end
            TC_INT:  state_nxt = (mode == MODE_RELOAD) ? TC_LOAD : TC_IDLE;
            default: state_nxt = TC_IDLE;
        endcase
    end

    // Per-state actions on the datapath registers.
    always_comb begin
        do_load   = (state == TC_LOAD);
        do_dec    = (state == TC_CNT) && en && (count > 32'd1);
        do_zero   = (state == TC_CNT) && en && (count <= 32'd1);
        do_set    = (state == TC_INT);
        do_disarm = (state == TC_INT) && (mode != MODE_RELOAD);
    end

    // CTRL: a CPU write overrides the one-shot self-disable on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en   <= 1'b0;
            mode <= MODE_ONESHOT;
            im   <= 1'b0;
        end else if (wr_ctrl) begin
            en   <= wdata[CTRL_EN];
            mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            im   <= wdata[CTRL_IM];
        end else if (do_disarm) begin
            en   <= 1'b0;
        end
    end

    // PRESET only reaches COUNT on the next LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         preset <= 32'd0;
        else if (wr_preset) preset <= wdata;
    end

    // COUNT is driven only by the FSM; CPU writes never reach it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       count <= 32'd0;
        else if (do_load) count <= preset;
        else if (do_dec)  count <= count - 32'd1;
        else if (do_zero) count <= 32'd0;
    end

    // Interrupt flag: set beats clear; reload mode self-clears after one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            int_flag <= 1'b0;
        else if (do_set)
            int_flag <= 1'b1;
        else if (wr_ctrl || wr_preset || (int_flag && (mode == MODE_RELOAD)))
            int_flag <= 1'b0;
    end

    // Register read mux.
    always_comb begin
        rdata = 32'd0;
        case (sel)
            TC_SEL_CTRL:   rdata = {28'd0, im, mode, en};
            TC_SEL_PRESET: rdata = preset;
            TC_SEL_COUNT:  rdata = count;
            default:       rdata = 32'd0;
        endcase
    end

    assign irq = int_flag & im;

endmodule

// File: rtl/dm_bridge.sv
// rtl/dm_bridge.sv - data-memory bridge: word RAM with byte lanes plus TC0 timer
module dm_bridge
    import dm_bridge_pkg::*;
#(
    parameter int          DM_WORDS = 3072,
    parameter logic [31:0] TC_BASE  = dm_bridge_pkg::TC_BASE,
    parameter int          LOG_EN   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DM_PC,
    input  logic [31:0] DM_Addr,
    input  logic [31:0] DM_WData,
    input  logic [3:0]  DM_WE,
    output logic [31:0] DM_RData,
    output logic        tc_irq
);

    localparam int          IDX_W     = $clog2(DM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DM_WORDS);

    logic [31:0] ram [DM_WORDS];

    logic             hit_ram;
    logic             ram_wr;
    logic [IDX_W-1:0] idx;
    logic [31:0]      ram_rd;
    logic [31:0]      wr_merged;

    tc_sel_e          tc_sel;
    logic             hit_tc;
    logic             tc_wr;
    logic [31:0]      tc_rdata;

    assign hit_ram = DM_Addr < RAM_BYTES;
    assign idx     = DM_Addr[IDX_W+1:2];
    assign ram_rd  = ram[idx];
    assign ram_wr  = hit_ram && (DM_WE != 4'b0000);

    // Timer word decode; only the three exact register addresses hit.
    always_comb begin
        tc_sel = TC_SEL_NONE;
        if      (DM_Addr == TC_BASE + TC_CTRL_OFF)   tc_sel = TC_SEL_CTRL;
        else if (DM_Addr == TC_BASE + TC_PRESET_OFF) tc_sel = TC_SEL_PRESET;
        else if (DM_Addr == TC_BASE + TC_COUNT_OFF)  tc_sel = TC_SEL_COUNT;
    end

    assign hit_tc = (tc_sel != TC_SEL_NONE);
    assign tc_wr  = hit_tc && (DM_WE == 4'b1111);

    // Lane merge of store data over the current word.
    always_comb begin
        wr_merged = ram_rd;
        for (int i = 0; i < 4; i++) begin
            if (DM_WE[i]) wr_merged[8*i +: 8] = DM_WData[8*i +: 8];
        end
    end

    // RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr) ram[idx] <= wr_merged;
    end

    // Same-cycle read mux; unmapped space reads as zero.
    always_comb begin
        if (hit_ram)     DM_RData = ram_rd;
        else if (hit_tc) DM_RData = tc_rdata;
        else             DM_RData = 32'd0;
    end

    dm_bridge_tc_timer u_tc (
        .clk   (clk),
        .reset (reset),
        .sel   (tc_sel),
        .wr    (tc_wr),
        .wdata (DM_WData),
        .rdata (tc_rdata),
        .irq   (tc_irq)
    );

    // Write-log taps: the simulation environment prints these on each accepted
    // RAM write; no datapath logic consumes them.
    logic        log_fire;
    logic [31:0] log_pc;
    logic [31:0] log_addr;
    logic [31:0] log_word;
    logic        unused_log;

    assign log_fire   = ram_wr && (LOG_EN != 0);
    assign log_pc     = DM_PC;
    assign log_addr   = DM_Addr;
    assign log_word   = wr_merged;
    assign unused_log = ^{log_fire, log_pc, log_addr, log_word};

endmodule

// File: tb/tb_dm_bridge.sv
// tb/tb_dm_bridge.sv - self-checking bench for dm_bridge against a behavioural model
module tb_dm_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] DM_PC;
    logic [31:0] DM_Addr;
    logic [31:0] DM_WData;
    logic [3:0]  DM_WE;
    logic [31:0] DM_RData;
    logic        tc_irq;

    always #5 clk = ~clk;

    dm_bridge #(.DM_WORDS(3072), .TC_BASE(32'h0000_7F00), .LOG_EN(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .DM_PC    (DM_PC),
        .DM_Addr  (DM_Addr),
        .DM_WData (DM_WData),
        .DM_WE    (DM_WE),
        .DM_RData (DM_RData),
        .tc_irq   (tc_irq)
    );

    // Write log printed from the bridge's log taps.
    always @(posedge clk) begin
        if (dut.log_fire) $display("@%h: *%h <= %h", dut.log_pc, dut.log_addr, dut.log_word);
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // ---------------- reference model ----------------
    typedef enum int {PH_IDLE, PH_LOAD, PH_COUNT, PH_FIRE} phase_t;

    logic [31:0] m_ram [bit [31:0]];
    bit          m_en, m_im, m_flag;
    bit   [1:0]  m_mode;
    bit   [31:0] m_preset, m_count;
    phase_t      m_phase;

    task automatic model_reset();
        m_en = 0; m_im = 0; m_flag = 0; m_mode = 2'b00;
        m_preset = 0; m_count = 0; m_phase = PH_IDLE;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < 32'h3000) return m_ram.exists(a) ? m_ram[a] : 32'hxxxx_xxxx;
        if (a == 32'h7F00) return {28'd0, m_im, m_mode, m_en};
        if (a == 32'h7F04) return m_preset;
        if (a == 32'h7F08) return m_count;
        return 32'd0;
    endfunction

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] old_w, new_w;
        bit          wfull, w_ctrl, w_pre, set_f;
        bit          n_en, n_im, n_flag;
        bit   [1:0]  n_mode;
        bit   [31:0] n_preset, n_count;
        phase_t      n_phase;
        if (DM_Addr < 32'h3000 && DM_WE != 4'b0000) begin
            old_w = m_ram.exists(DM_Addr) ? m_ram[DM_Addr] : 32'h0;
            new_w = old_w;
            for (int i = 0; i < 4; i++)
                if (DM_WE[i]) new_w[8*i +: 8] = DM_WData[8*i +: 8];
            m_ram[DM_Addr] = new_w;
        end
        if (reset) begin
            wfull  = (DM_WE == 4'hF);
            w_ctrl = wfull && (DM_Addr == 32'h7F00);
            w_pre  = wfull && (DM_Addr == 32'h7F04);
            set_f  = 0;
            n_en = m_en; n_im = m_im; n_mode = m_mode; n_flag = m_flag;
            n_preset = m_preset; n_count = m_count; n_phase = m_phase;
            case (m_phase)
                PH_IDLE:  if (m_en) n_phase = PH_LOAD;
                PH_LOAD:  begin n_count = m_preset; n_phase = PH_COUNT; end
                PH_COUNT: begin
                    if (!m_en)           n_phase = PH_IDLE;
                    else if (m_count > 1) n_count = m_count - 1;
                    else begin n_count = 0; n_phase = PH_FIRE; end
                end
                PH_FIRE: begin
                    set_f = 1;
                    if (m_mode == 2'b01) n_phase = PH_LOAD;
                    else begin n_en = 0; n_phase = PH_IDLE; end
                end
                default: n_phase = PH_IDLE;
            endcase
            if (w_ctrl) begin n_en = DM_WData[0]; n_mode = DM_WData[2:1]; n_im = DM_WData[3]; end
            if (w_pre) n_preset = DM_WData;
            if (set_f) n_flag = 1;
            else if (w_ctrl || w_pre || (m_flag && m_mode == 2'b01)) n_flag = 0;
            m_en = n_en; m_im = n_im; m_mode = n_mode; m_flag = n_flag;
            m_preset = n_preset; m_count = n_count; m_phase = n_phase;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        DM_PC    = $urandom & 32'hFFFF_FFFC;
        DM_Addr  = a;
        DM_WData = d;
        DM_WE    = we;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive, compare combinational read and irq, then clock.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] e;
        drive(a, d, we);
        #1;
        e = m_read(a);
        if (!$isunknown(e)) check(tag, DM_RData, e);
        check({tag, "_irq"}, {31'd0, tc_irq}, {31'd0, m_flag & m_im});
        tick();
    endtask

    task automatic watch(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 32'h7F08, 32'd0, 4'b0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d;
        logic [3:0]  we;
        logic [31:0] words [9];

        model_reset();
        reset = 1'b0;
        drive(32'h7F00, 32'd0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", DM_RData, 32'd0);
        check("rst_irq", {31'd0, tc_irq}, 32'd0);
        drive(32'h7F04, 32'd0, 4'b0000); #1;
        check("rst_preset", DM_RData, 32'd0);
        drive(32'h7F08, 32'd0, 4'b0000); #1;
        check("rst_count", DM_RData, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Full write, lane write, null write.
        step("s1_wr", 32'h10, 32'hDEAD_BEEF, 4'b1111);
        drive(32'h10, 32'd0, 4'b0000); #1;
        check("s1_rd", DM_RData, 32'hDEAD_BEEF);
        step("s2_wr", 32'h10, 32'h00AB_0000, 4'b0100);
        drive(32'h10, 32'd0, 4'b0000); #1;
        check("s2_lane", DM_RData, 32'hDEAB_BEEF);
        step("s2_nowe", 32'h10, 32'hFFFF_FFFF, 4'b0000);
        drive(32'h10, 32'd0, 4'b0000); #1;
        check("s2_keep", DM_RData, 32'hDEAB_BEEF);

        // Randomised RAM traffic over a small word set including the top word.
        for (int i = 0; i < 8; i++) words[i] = 32'(i * 4);
        words[8] = 32'h2FFC;
        for (int i = 0; i < 9; i++) step("ram_init", words[i], $urandom, 4'b1111);
        for (int i = 0; i < 40; i++) begin
            a  = words[$urandom_range(0, 8)];
            we = 4'($urandom_range(0, 15));
            step("ram_wr_old", a, $urandom, we);
            step("ram_rd", words[$urandom_range(0, 8)], 32'd0, 4'b0000);
        end

        // One-shot from 3 with interrupt enabled.
        step("s3_pre", 32'h7F04, 32'd3, 4'b1111);
        step("s3_ctrl", 32'h7F00, 32'h9, 4'b1111);
        watch("s3_cnt", 8);
        drive(32'h7F00, 32'd0, 4'b0000); #1;
        check("s3_en_off", DM_RData, 32'h8);
        check("s3_irq_held", {31'd0, tc_irq}, 32'd1);
        step("s3_clr", 32'h7F00, 32'h8, 4'b1111);
        check("s3_irq_drop", {31'd0, tc_irq}, 32'd0);

        // Auto-reload from 2.
        step("s4_pre", 32'h7F04, 32'd2, 4'b1111);
        step("s4_ctrl", 32'h7F00, 32'hB, 4'b1111);
        watch("s4_run", 18);
        step("s4_stop", 32'h7F00, 32'h0, 4'b1111);

        // Counting from 10, then disable, COUNT write and partial PRESET write.
        step("s5_pre", 32'h7F04, 32'd10, 4'b1111);
        step("s5_ctrl", 32'h7F00, 32'h1, 4'b1111);
        watch("s5_run", 5);
        step("s5_dis", 32'h7F00, 32'h0, 4'b1111);
        watch("s5_frz", 3);
        step("s5_cnt_wr", 32'h7F08, 32'h55, 4'b1111);
        step("s5_part", 32'h7F04, 32'h1234, 4'b0011);
        step("s5_preset", 32'h7F04, 32'd0, 4'b0000);
        drive(32'h7F04, 32'd0, 4'b0000); #1;
        check("s5_preset_k", DM_RData, 32'd10);

        // Randomised timer runs over presets 0..4 and all modes.
        for (int r = 0; r < 5; r++) begin
            step("rt_pre", 32'h7F04, 32'($urandom_range(0, 4)), 4'b1111);
            d = {28'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            step("rt_ctrl", 32'h7F00, d, 4'b1111);
            watch("rt_run", 14);
            step("rt_stop", 32'h7F00, 32'h0, 4'b1111);
        end

        // Asynchronous reset mid-count.
        step("s6_pre", 32'h7F04, 32'd20, 4'b1111);
        step("s6_ctrl", 32'h7F00, 32'h9, 4'b1111);
        watch("s6_run", 5);
        drive(32'h7F08, 32'd0, 4'b0000);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("s6_cnt0", DM_RData, 32'd0);
        check("s6_irq0", {31'd0, tc_irq}, 32'd0);
        tick();
        reset = 1'b1;
        step("s6_ctrl0", 32'h7F00, 32'd0, 4'b0000);
        drive(32'h3000, 32'd0, 4'b0000); #1;
        check("s6_unm_ram", DM_RData, 32'd0);
        drive(32'h7F0C, 32'd0, 4'b0000); #1;
        check("s6_unm_tc", DM_RData, 32'd0);
        step("s6_wr_ram", 32'h3000, 32'hCAFE_F00D, 4'b1111);
        step("s6_wr_tc", 32'h7F0C, 32'hFFFF_FFFF, 4'b1111);
        step("s6_unm_ram2", 32'h3000, 32'd0, 4'b0000);
        step("s6_unm_tc2", 32'h7F0C, 32'd0, 4'b0000);
        step("s6_ctrl_k", 32'h7F00, 32'd0, 4'b0000);
        step("s6_ram_k", 32'h10, 32'd0, 4'b0000);
        step("s6_ram0_k", 32'h0, 32'd0, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
